sobel_window_ctrl: RTL and testbench

//  Sequencer for the 5x5 Sobel window pipeline (line FIFOs + 5-tap shift rows + Gx/Gy stage).

---
 rtl/sobel_window_ctrl_pkg.sv | 26 ++
 rtl/sobel_window_ctrl_if.sv | 28 ++
 rtl/sobel_window_ctrl_valid_delay.sv | 37 +++
 rtl/sobel_window_ctrl.sv | 106 ++++++++++
 tb/tb_sobel_window_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_window_ctrl_pkg.sv
// Shared geometry, coordinate type and controller state encoding for the 5x5 Sobel window sequencer.
// The default image size is 800x600, and the kernel size is fixed at 5.
package sobel_window_ctrl_pkg;

  localparam int DEF_IMG_W = 800;
  localparam int DEF_IMG_H = 600;
  localparam int K         = 5;
  localparam int BORDER    = K / 2;
  localparam int COORD_W   = 10;
  localparam int N_LB      = K - 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic   vld;
    coord_t cx;
    coord_t cy;
  } win_tag_t;

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-side qualifiers in, Sobel datapath enables and result tags out.
// The master side is the camera/datapath and the slave side is the controller.
interface sobel_window_ctrl_if;
  import sobel_window_ctrl_pkg::*;

  logic            pix_valid;
  logic            sof;
  logic            shift_en;
  logic [N_LB-1:0] lb_wr_en;
  logic [N_LB-1:0] lb_rd_en;
  logic            win_valid;
  logic            edge_valid;
  coord_t          cx;
  coord_t          cy;
  logic            frame_done;
  logic            sync_err;

  modport master (
    output pix_valid, sof,
    input  shift_en, lb_wr_en, lb_rd_en, win_valid, edge_valid, cx, cy, frame_done, sync_err
  );

  modport slave (
    input  pix_valid, sof,
    output shift_en, lb_wr_en, lb_rd_en, win_valid, edge_valid, cx, cy, frame_done, sync_err
  );

endinterface

// File: rtl/sobel_window_ctrl_valid_delay.sv
// DP_LAT-deep free-running delay of {valid, cx, cy}, so that tags line up with the registered Gx/Gy.
// The delay advances every cycle and is not stalled by pixel gaps; all stages reset to zero.
module sobel_window_ctrl_valid_delay
  import sobel_window_ctrl_pkg::*;
#(
  parameter int DP_LAT = 1
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   vld_in,
  input  coord_t cx_in,
  input  coord_t cy_in,
  output logic   vld_out,
  output coord_t cx_out,
  output coord_t cy_out
);

  if (DP_LAT < 1) begin : g_lat_chk
    $error("DP_LAT must be at least 1");
  end

  win_tag_t stage [DP_LAT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DP_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{vld: vld_in, cx: cx_in, cy: cy_in};
      for (int i = 1; i < DP_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign vld_out = stage[DP_LAT-1].vld;
  assign cx_out  = stage[DP_LAT-1].cx;
  assign cy_out  = stage[DP_LAT-1].cy;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the 5x5 Sobel pipeline. Shift and line-buffer enables are combinational from pix_valid.
// win_valid, frame_done and sync_err are delayed by 1 cycle, and edge_valid by 1+DP_LAT cycles. Gaps in pix_valid hold all frame state.
module sobel_window_ctrl
  import sobel_window_ctrl_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int DP_LAT   = 1,
  parameter int LB_DEPTH = DEF_IMG_W
) (
  input  logic clock,
  input  logic reset_n,
  sobel_window_ctrl_if.slave bus
);

  localparam coord_t X_LAST  = coord_t'(IMG_W - 1);
  localparam coord_t Y_LAST  = coord_t'(IMG_H - 1);
  localparam coord_t WIN_MIN = coord_t'(K - 1);
  localparam coord_t OFS     = coord_t'(BORDER);

  if (IMG_W > (1 << COORD_W) || IMG_H > (1 << COORD_W)) begin : g_dim_chk
    $error("image dimensions exceed the coordinate width");
  end
  if (LB_DEPTH < IMG_W - K) begin : g_lb_chk
    $error("line FIFO depth too small for the image width");
  end

  state_t          state;
  coord_t          x, y;
  coord_t          px, py, x_nxt, y_nxt;
  logic            restart, accept, last_pix, win_hit, bad_sync;
  logic [N_LB-1:0] rd_en;
  logic            win_valid_q, frame_done_q, sync_err_q;
  coord_t          win_cx_q, win_cy_q;

  // A sof pixel is always treated as (0,0), even in the middle of a frame.
  always_comb begin
    restart  = bus.pix_valid & bus.sof;
    accept   = bus.pix_valid & (bus.sof | (state != ST_IDLE));
    px       = restart ? '0 : x;
    py       = restart ? '0 : y;
    last_pix = accept & ~restart & (px == X_LAST) & (py == Y_LAST);
    win_hit  = accept & (px >= WIN_MIN) & (py >= WIN_MIN);
    bad_sync = bus.pix_valid & (bus.sof ? (state != ST_IDLE) : (state == ST_IDLE));
    x_nxt    = px + coord_t'(1);
    y_nxt    = py;
    if (px == X_LAST) begin
      x_nxt = '0;
      y_nxt = py + coord_t'(1);
    end
    rd_en = '0;
    for (int k = 0; k < N_LB; k++) rd_en[k] = accept & (py > coord_t'(k));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      x            <= '0;
      y            <= '0;
      win_valid_q  <= 1'b0;
      win_cx_q     <= '0;
      win_cy_q     <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      win_valid_q  <= win_hit;
      frame_done_q <= last_pix;
      sync_err_q   <= bad_sync;
      if (win_hit) begin
        win_cx_q <= px - OFS;
        win_cy_q <= py - OFS;
      end
      if (accept) begin
        if (last_pix) begin
          state <= ST_IDLE;
          x     <= '0;
          y     <= '0;
        end else begin
          x     <= x_nxt;
          y     <= y_nxt;
          state <= (y_nxt >= WIN_MIN) ? ST_RUN : ST_PRIME;
        end
      end
    end
  end

  // The sof pixel that opens a frame is written too, because row 0 must enter the line buffers.
  assign bus.shift_en   = accept;
  assign bus.lb_wr_en   = {N_LB{accept}};
  assign bus.lb_rd_en   = rd_en;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;

  sobel_window_ctrl_valid_delay #(.DP_LAT(DP_LAT)) u_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .vld_in  (win_valid_q),
    .cx_in   (win_cx_q),
    .cy_in   (win_cy_q),
    .vld_out (bus.edge_valid),
    .cx_out  (bus.cx),
    .cy_out  (bus.cy)
  );

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed and random pixel streams on an 8x6 image, checked against a pixel-index reference model.
// Two instances run in lockstep: one with DP_LAT=1 and one with DP_LAT=3.
module tb_sobel_window_ctrl;
  import sobel_window_ctrl_pkg::*;

  localparam int W = 8;
  localparam int H = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sobel_window_ctrl_if bus1();
  sobel_window_ctrl_if bus3();
  assign bus3.pix_valid = bus1.pix_valid;
  assign bus3.sof       = bus1.sof;

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .DP_LAT(1), .LB_DEPTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus1));
  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .DP_LAT(3), .LB_DEPTH(W)) dut3 (
    .clock(clock), .reset_n(reset_n), .bus(bus3));

  typedef struct {
    bit v;
    int cx;
    int cy;
  } ev_t;

  int  total = 0;
  int  bad   = 0;
  ev_t win_log[$];
  int  got_x[$], got_y[$], ref_x[$], ref_y[$];
  int  fd_cnt, se_cnt;
  bit  in_frame;
  int  n_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t exp_at(input int lat);
    ev_t e;
    int  idx;
    e   = '{0, 0, 0};
    idx = win_log.size() - 1 - lat;
    if (idx >= 0) e = win_log[idx];
    return e;
  endfunction

  task automatic clear_model();
    in_frame = 0;
    n_pix    = 0;
    win_log.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_shift"}, 32'(bus1.shift_en), 0);
    chk({tag, "_wr"}, 32'(bus1.lb_wr_en), 0);
    chk({tag, "_rd"}, 32'(bus1.lb_rd_en), 0);
    chk({tag, "_win"}, 32'(bus1.win_valid), 0);
    chk({tag, "_edge"}, 32'(bus1.edge_valid), 0);
    chk({tag, "_cx"}, 32'(bus1.cx), 0);
    chk({tag, "_cy"}, 32'(bus1.cy), 0);
    chk({tag, "_fd"}, 32'(bus1.frame_done), 0);
    chk({tag, "_se"}, 32'(bus1.sync_err), 0);
    chk({tag, "_edge3"}, 32'(bus3.edge_valid), 0);
  endtask

  // One clock cycle: drive the inputs, check the combinational enables, then check the registered outputs after the edge.
  task automatic step(input bit v, input bit s);
    bit         acc, exp_se, exp_fd;
    logic [3:0] exp_rd;
    int         px, py;
    ev_t        w, e1, e3;
    acc = 0; exp_se = 0; exp_fd = 0; exp_rd = '0; w = '{0, 0, 0};
    bus1.pix_valid = v;
    bus1.sof       = s;
    if (v) begin
      if (s) begin
        exp_se   = in_frame;
        in_frame = 1;
        n_pix    = 0;
        acc      = 1;
      end else if (!in_frame) begin
        exp_se = 1;
      end else begin
        acc = 1;
      end
    end
    if (acc) begin
      px = n_pix % W;
      py = n_pix / W;
      for (int k = 0; k < 4; k++) exp_rd[k] = (py > k);
      if (px >= 4 && py >= 4) w = '{1, px - 2, py - 2};
      n_pix++;
      if (n_pix == W * H) begin
        exp_fd   = 1;
        in_frame = 0;
        n_pix    = 0;
      end
    end
    win_log.push_back(w);
    #1;
    chk("shift_en", 32'(bus1.shift_en), 32'(acc));
    chk("lb_wr_en", 32'(bus1.lb_wr_en), acc ? 32'hF : 32'h0);
    chk("lb_rd_en", 32'(bus1.lb_rd_en), 32'(exp_rd));
    @(posedge clock);
    #1;
    e1 = exp_at(1);
    e3 = exp_at(3);
    chk("win_valid", 32'(bus1.win_valid), 32'(w.v));
    chk("frame_done", 32'(bus1.frame_done), 32'(exp_fd));
    chk("sync_err", 32'(bus1.sync_err), 32'(exp_se));
    chk("edge_valid", 32'(bus1.edge_valid), 32'(e1.v));
    chk("edge_valid3", 32'(bus3.edge_valid), 32'(e3.v));
    if (e1.v) begin
      chk("cx", 32'(bus1.cx), 32'(e1.cx));
      chk("cy", 32'(bus1.cy), 32'(e1.cy));
    end
    if (e3.v) begin
      chk("cx3", 32'(bus3.cx), 32'(e3.cx));
      chk("cy3", 32'(bus3.cy), 32'(e3.cy));
    end
    if (bus1.edge_valid === 1'b1) begin
      got_x.push_back(int'(bus1.cx));
      got_y.push_back(int'(bus1.cy));
    end
    if (bus1.frame_done === 1'b1) fd_cnt++;
    if (bus1.sync_err === 1'b1) se_cnt++;
  endtask

  task automatic clear_obs();
    got_x.delete();
    got_y.delete();
    fd_cnt = 0;
    se_cnt = 0;
  endtask

  task automatic run_frame(input bit gaps);
    for (int p = 0; p < W * H; p++) begin
      step(1, p == 0);
      if (gaps) step(0, 0);
    end
    repeat (5) step(0, 0);
  endtask

  initial begin
    bus1.pix_valid = 0;
    bus1.sof       = 0;
    clear_model();
    clear_obs();
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    #2 reset_n = 1;

    // Pixels with no preceding sof are dropped.
    repeat (3) step(1, 0);
    step(0, 0);
    chk("stray_sync_err_cnt", 32'(se_cnt), 3);

    // A continuous frame: 8 interior windows, from centre (2,2) through (5,3).
    clear_obs();
    run_frame(0);
    chk("cont_win_cnt", 32'(got_x.size()), 8);
    if (got_x.size() == 8) begin
      chk("cont_first_cx", 32'(got_x[0]), 2);
      chk("cont_first_cy", 32'(got_y[0]), 2);
      chk("cont_last_cx", 32'(got_x[7]), 5);
      chk("cont_last_cy", 32'(got_y[7]), 3);
    end
    chk("cont_fd_cnt", 32'(fd_cnt), 1);
    ref_x = got_x;
    ref_y = got_y;

    // The same frame with a gap after every pixel must give the same window sequence.
    clear_obs();
    run_frame(1);
    chk("gap_win_cnt", 32'(got_x.size()), 32'(ref_x.size()));
    for (int i = 0; i < got_x.size() && i < ref_x.size(); i++) begin
      chk("gap_seq_cx", 32'(got_x[i]), 32'(ref_x[i]));
      chk("gap_seq_cy", 32'(got_y[i]), 32'(ref_y[i]));
    end
    chk("gap_fd_cnt", 32'(fd_cnt), 1);

    // A sof at pixel 20 aborts the frame; only the restarted frame completes.
    clear_obs();
    for (int p = 0; p < 20; p++) step(1, p == 0);
    for (int p = 0; p < W * H; p++) step(1, p == 0);
    repeat (5) step(0, 0);
    chk("abort_se_cnt", 32'(se_cnt), 1);
    chk("abort_fd_cnt", 32'(fd_cnt), 1);
    chk("abort_win_cnt", 32'(got_x.size()), 8);

    // Random gaps and occasional sof pulses, tracked cycle by cycle by the model.
    clear_obs();
    step(1, 1);
    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 79) == 0);
      step(v, s);
    end
    repeat (5) step(0, 0);

    // Assert reset asynchronously in the middle of a running frame.
    clear_obs();
    for (int p = 0; p < 37; p++) step(1, p == 0);
    bus1.pix_valid = 1;
    bus1.sof       = 0;
    #3 reset_n = 0;
    #1;
    chk_all_zero("async_rst");
    clear_model();
    bus1.pix_valid = 0;
    @(posedge clock);
    #2 reset_n = 1;
    clear_obs();
    run_frame(0);
    chk("post_rst_win_cnt", 32'(got_x.size()), 8);
    chk("post_rst_fd_cnt", 32'(fd_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
